// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, result, ALU and debug signal bundle.
// Carries cmd_rep only when ALU_SEQ_REPEAT_EN is defined.
interface alu_sequencer_if #(
   parameter int NREGS = 4
);
   localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [IW-1:0] cmd_rd;
   logic [IW-1:0] cmd_rs;
   logic [IW-1:0] cmd_rt;
   logic          cmd_use_imm;
   logic [7:0]    cmd_imm;
`ifdef ALU_SEQ_REPEAT_EN
   logic [2:0]    cmd_rep;
`endif
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [2:0]    alu_cntr;
   logic [7:0]    alu_r;
   logic [2:0]    alu_flags;
   logic          res_valid;
   logic          res_ready;
   logic [7:0]    res_data;
   logic [2:0]    res_flags;
   logic          res_err;
   logic [IW-1:0] dbg_sel;
   logic [7:0]    dbg_data;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
      output cmd_use_imm, cmd_imm,
`ifdef ALU_SEQ_REPEAT_EN
      output cmd_rep,
`endif
      input  cmd_ready,
      input  alu_a, alu_b, alu_cntr,
      output alu_r, alu_flags,
      input  res_valid, res_data, res_flags, res_err,
      output res_ready,
      output dbg_sel,
      input  dbg_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
      input  cmd_use_imm, cmd_imm,
`ifdef ALU_SEQ_REPEAT_EN
      input  cmd_rep,
`endif
      output cmd_ready,
      output alu_a, alu_b, alu_cntr,
      input  alu_r, alu_flags,
      output res_valid, res_data, res_flags, res_err,
      input  res_ready,
      input  dbg_sel,
      output dbg_data
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/RESP controller around a shared 8-bit ALU.
// Define ALU_SEQ_REPEAT_EN for repeated EXEC iterations (cmd_rep).
module alu_sequencer #(
   parameter int         NREGS     = 4,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input logic            clk,
   input logic            reset,
   alu_sequencer_if.slave bus
);
   localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_regs [NREGS];
   logic [2:0]    r_op;
   logic [IW-1:0] r_rd;
   logic [IW-1:0] r_rs;
   logic [IW-1:0] r_rt;
   logic          r_use_imm;
   logic [7:0]    r_imm;
   logic [7:0]    r_hold_a;
   logic [7:0]    r_hold_b;
   logic [7:0]    r_res_data;
   logic [2:0]    r_res_flags;
   logic          r_res_err;
   logic          w_rdy;
   logic          w_resv;
   logic          w_accept;
   logic          w_exec;
   logic          w_wr;
   logic          w_last;
   logic          w_illegal;
   logic [7:0]    w_a;
   logic [7:0]    w_b;
   logic          w_carry;

   assign w_illegal = r_op[2] & r_op[1];

`ifdef ALU_SEQ_REPEAT_EN
   logic [2:0] r_rep;
   logic [2:0] r_iter;

   // Later iterations chain on the previous result with B frozen.
   assign w_a = (r_iter == 3'd0) ? r_regs[r_rs] : r_res_data;
   assign w_b = (r_iter != 3'd0) ? r_hold_b :
                r_use_imm ? r_imm : r_regs[r_rt];
   assign w_last  = w_illegal | (r_iter == r_rep);
   assign w_carry = bus.alu_flags[2] |
                    ((r_iter != 3'd0) & r_res_flags[2]);

   // Iteration counter, restarted by every accepted command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep  <= 3'd0;
         r_iter <= 3'd0;
      end else if (w_accept) begin
         r_rep  <= bus.cmd_rep;
         r_iter <= 3'd0;
      end else if (w_exec && !w_last) begin
         r_iter <= r_iter + 3'd1;
      end
   end
`else
   assign w_a     = r_regs[r_rs];
   assign w_b     = r_use_imm ? r_imm : r_regs[r_rt];
   assign w_last  = 1'b1;
   assign w_carry = bus.alu_flags[2];
`endif

   // Next-state and per-state strobes.
   always_comb begin
      w_next   = r_state;
      w_rdy    = 1'b0;
      w_resv   = 1'b0;
      w_accept = 1'b0;
      w_exec   = 1'b0;
      w_wr     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_rdy = 1'b1;
            if (bus.cmd_valid) begin
               w_accept = 1'b1;
               w_next   = EXEC;
            end
         end
         EXEC: begin
            w_exec = 1'b1;
            w_wr   = ~w_illegal;
            if (w_last) w_next = RESP;
         end
         RESP: begin
            w_resv = 1'b1;
            if (bus.res_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Command fields latched on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op      <= 3'd0;
         r_rd      <= '0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_use_imm <= 1'b0;
         r_imm     <= 8'h00;
      end else if (w_accept) begin
         r_op      <= bus.cmd_op;
         r_rd      <= bus.cmd_rd;
         r_rs      <= bus.cmd_rs;
         r_rt      <= bus.cmd_rt;
         r_use_imm <= bus.cmd_use_imm;
         r_imm     <= bus.cmd_imm;
      end
   end

   // Register file writeback and result capture in EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= RESET_VAL;
         r_hold_a    <= 8'h00;
         r_hold_b    <= 8'h00;
         r_res_data  <= 8'h00;
         r_res_flags <= 3'b000;
         r_res_err   <= 1'b0;
      end else begin
         if (w_accept) r_res_err <= 1'b0;
         if (w_exec) begin
            r_hold_a    <= w_a;
            r_hold_b    <= w_b;
            r_res_data  <= bus.alu_r;
            r_res_flags <= {w_carry, bus.alu_flags[1:0]};
            if (w_illegal) r_res_err <= 1'b1;
            if (w_wr) r_regs[r_rd] <= bus.alu_r;
         end
      end
   end

   assign bus.cmd_ready = w_rdy & ~reset;
   assign bus.res_valid = w_resv;
   assign bus.res_data  = r_res_data;
   assign bus.res_flags = r_res_flags;
   assign bus.res_err   = r_res_err;
   assign bus.alu_a     = w_exec ? w_a : r_hold_a;
   assign bus.alu_b     = w_exec ? w_b : r_hold_b;
   assign bus.alu_cntr  = w_exec ? r_op : 3'b000;
   assign bus.dbg_data  = r_regs[bus.dbg_sel];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: vector table, corner sequences and random commands
// checked against a command-level register-file model.
module tb_alu_sequencer;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Combinational ALU: R and {Carry, Greater, Equal}.
   function automatic logic [10:0] alu_ref(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      s = 9'd0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = ~b;
         3'd2: r = a ^ b;
         3'd3: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
         3'd4: r = a - b;
         3'd5: r = b;
         default: r = 8'h00;
      endcase
      if (op > 3'd5) return 11'd0;
      return {c, a > b, a == b, r};
   endfunction

   always_comb begin
      {bus.alu_flags, bus.alu_r} = alu_ref(bus.alu_cntr, bus.alu_a, bus.alu_b);
   end

   logic [7:0] mref [4];
   logic [7:0] e_data;
   logic [2:0] e_flags;
   logic       e_err;
   int         e_lat;

`ifdef ALU_SEQ_REPEAT_EN
   localparam int MAXREP = 3;
`else
   localparam int MAXREP = 0;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt,
                        input logic ui, input logic [7:0] imm,
                        input logic [2:0] rep);
      logic [7:0]  a;
      logic [7:0]  b;
      logic [10:0] o;
      logic        cor;
      a   = mref[rs];
      b   = ui ? imm : mref[rt];
      cor = 1'b0;
      o   = 11'd0;
      if (op > 3'd5) begin
         e_data = 8'h00; e_flags = 3'b000; e_err = 1'b1; e_lat = 2;
         return;
      end
      for (int i = 0; i <= int'(rep); i++) begin
         o   = alu_ref(op, a, b);
         cor = cor | o[10];
         a   = o[7:0];
      end
      mref[rd] = a;
      e_data   = a;
      e_flags  = {cor, o[9:8]};
      e_err    = 1'b0;
      e_lat    = int'(rep) + 2;
   endtask

   task automatic drive(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt,
                        input logic ui, input logic [7:0] imm,
                        input logic [2:0] rep);
      bus.cmd_op      = op;
      bus.cmd_rd      = rd;
      bus.cmd_rs      = rs;
      bus.cmd_rt      = rt;
      bus.cmd_use_imm = ui;
      bus.cmd_imm     = imm;
`ifdef ALU_SEQ_REPEAT_EN
      bus.cmd_rep     = rep;
`else
      if (rep != 3'd0) $display("note: rep ignored in this build");
`endif
      bus.cmd_valid   = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge of the cycle after accept.
   task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt,
                        input logic ui, input logic [7:0] imm,
                        input logic [2:0] rep);
      int n;
      n = 0;
      drive(op, rd, rs, rt, ui, imm, rep);
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) chk("cmd_ready_wait", bus.cmd_ready, 1);
      model(op, rd, rs, rt, ui, imm, rep);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic collect(output int lat);
      lat = 1;
      while (!bus.res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.res_valid) chk("res_valid_wait", bus.res_valid, 1);
   endtask

   task automatic take();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_valid_drop", bus.res_valid, 0);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [1:0] rt;
      logic       ui;
      logic [7:0] imm;
      logic [7:0] x_data;
      logic [2:0] x_flags;
      logic       x_err;
      logic [7:0] x_dbg;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int         lat;
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [1:0] rt;
      logic [1:0] sel;
      logic       ui;
      logic [7:0] imm;
      logic [2:0] rep;
      int         stall;

      vecs[0]  = '{3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'hC8, 8'hC8, 3'b000, 1'b0, 8'hC8};
      vecs[1]  = '{3'd3, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h90, 3'b101, 1'b0, 8'h90};
      vecs[2]  = '{3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 3'b000, 1'b0, 8'h05};
      vecs[3]  = '{3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 3'b000, 1'b0, 8'h05};
      vecs[4]  = '{3'd4, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, 3'b001, 1'b0, 8'h00};
      vecs[5]  = '{3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h06, 8'h06, 3'b000, 1'b0, 8'h06};
      vecs[6]  = '{3'd4, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'hFF, 3'b000, 1'b0, 8'hFF};
      vecs[7]  = '{3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'h3C, 8'h3C, 3'b000, 1'b0, 8'h3C};
      vecs[8]  = '{3'd7, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h3C};
      vecs[9]  = '{3'd0, 2'd0, 2'd2, 2'd0, 1'b1, 8'hF0, 8'h30, 3'b000, 1'b0, 8'h30};
      vecs[10] = '{3'd2, 2'd1, 2'd0, 2'd2, 1'b0, 8'h00, 8'h0C, 3'b000, 1'b0, 8'h0C};
      vecs[11] = '{3'd1, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00, 8'hF3, 3'b010, 1'b0, 8'hF3};
      vecs[12] = '{3'd6, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h30};
      vecs[13] = '{3'd3, 2'd0, 2'd3, 2'd0, 1'b1, 8'h0D, 8'h00, 3'b110, 1'b0, 8'h00};

      clk           = 1'b0;
      reset         = 1'b1;
      bus.res_ready = 1'b0;
      bus.dbg_sel   = 2'd0;
      drive(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0);
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) mref[i] = 8'h00;

      // Reset state.
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_flags", bus.res_flags, 0);
      chk("rst_res_err", bus.res_err, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_cntr", bus.alu_cntr, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", bus.cmd_ready, 1);

      // Vector table.
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt,
               vecs[i].ui, vecs[i].imm, 3'd0);
         collect(lat);
         chk($sformatf("v%0d_lat", i), lat, 2);
         chk($sformatf("v%0d_data", i), bus.res_data, vecs[i].x_data);
         chk($sformatf("v%0d_flags", i), bus.res_flags, vecs[i].x_flags);
         chk($sformatf("v%0d_err", i), bus.res_err, vecs[i].x_err);
         take();
         bus.dbg_sel = vecs[i].rd;
         #1;
         chk($sformatf("v%0d_dbg", i), bus.dbg_data, vecs[i].x_dbg);
         @(negedge clk);
      end

      // Result held under backpressure while another command waits.
      issue(3'd5, 2'd0, 2'd1, 2'd1, 1'b1, 8'h5A, 3'd0);
      collect(lat);
      chk("stall_first", bus.res_data, e_data);
      drive(3'd3, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", bus.res_valid, 1);
         chk("stall_ready", bus.cmd_ready, 0);
         chk("stall_data", bus.res_data, e_data);
         chk("stall_flags", bus.res_flags, e_flags);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("stall_idle_ready", bus.cmd_ready, 1);
      chk("stall_idle_valid", bus.res_valid, 0);
      model(3'd3, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 3'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("stall_exec_ready", bus.cmd_ready, 0);
      collect(lat);
      chk("stall_b_lat", lat, 2);
      chk("stall_b_data", bus.res_data, e_data);
      chk("stall_b_flags", bus.res_flags, e_flags);
      take();

      // Reset while a result is pending.
      issue(3'd5, 2'd3, 2'd0, 2'd0, 1'b1, 8'hAA, 3'd0);
      collect(lat);
      chk("mid_valid", bus.res_valid, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", bus.res_valid, 0);
      chk("mid_rst_ready", bus.cmd_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) mref[i] = 8'h00;
      @(negedge clk);
      chk("mid_post_ready", bus.cmd_ready, 1);
      chk("mid_post_valid", bus.res_valid, 0);
      chk("mid_post_data", bus.res_data, 0);
      for (int i = 0; i < 4; i++) begin
         bus.dbg_sel = 2'(i);
         #1;
         chk($sformatf("mid_dbg%0d", i), bus.dbg_data, 0);
      end
      @(negedge clk);

`ifdef ALU_SEQ_REPEAT_EN
      // Chained ADD over four iterations.
      issue(3'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'h07, 3'd0);
      collect(lat);
      take();
      issue(3'd3, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 3'd3);
      collect(lat);
      chk("rep_lat", lat, 5);
      chk("rep_data", bus.res_data, e_data);
      chk("rep_carry", bus.res_flags[2], 0);
      take();
      bus.dbg_sel = 2'd1;
      #1;
      chk("rep_dbg", bus.dbg_data, mref[1]);
      @(negedge clk);
`endif

      // Random commands.
      for (int n = 0; n < 80; n++) begin
         op   = 3'($urandom_range(0, 7));
         rd   = 2'($urandom_range(0, 3));
         rs   = 2'($urandom_range(0, 3));
         rt   = 2'($urandom_range(0, 3));
         ui   = 1'($urandom_range(0, 1));
         imm  = 8'($urandom_range(0, 255));
         rep  = 3'($urandom_range(0, MAXREP));
         issue(op, rd, rs, rt, ui, imm, rep);
         collect(lat);
         chk("rnd_lat", lat, e_lat);
         chk("rnd_data", bus.res_data, e_data);
         chk("rnd_flags", bus.res_flags, e_flags);
         chk("rnd_err", bus.res_err, e_err);
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("rnd_hold", {bus.res_valid, bus.res_data}, {1'b1, e_data});
         end
         take();
         sel = 2'($urandom_range(0, 3));
         bus.dbg_sel = sel;
         #1;
         chk("rnd_dbg", bus.dbg_data, mref[sel]);
         @(negedge clk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
